// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves at most STEP bit positions per cycle,
// with a valid/ready handshake on both the command and result sides.
`timescale 1ns/1ps
module iter_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  localparam logic [CNT_W-1:0] STEP_K = CNT_W'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [CNT_W-1:0]   step_k;
  logic [WIDTH-1:0]   shifted;

  // One step of the captured operation by min(remaining, STEP) positions.
  always_comb begin
    step_k  = (rem_q > STEP_K) ? STEP_K : rem_q;
    shifted = work_q;
    case (op_q)
      OP_ROL:  shifted = (work_q << step_k) | (work_q >> (WIDTH - 32'(step_k)));
      OP_SLL:  shifted = work_q << step_k;
      OP_ROR:  shifted = (work_q >> step_k) | (work_q << (WIDTH - 32'(step_k)));
      OP_SRL:  shifted = work_q >> step_k;
      OP_SRA:  shifted = $signed(work_q) >>> step_k;
      default: shifted = work_q;
    endcase
  end

  // Next-state, working register and registered handshake outputs.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    op_d       = op_q;
    rem_d      = rem_q;
    data_out_d = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          op_d    = op;
          // Reserved ops pass the operand straight through.
          rem_d   = (op > OP_SRA) ? '0 : shamt;
          state_d = (rem_d == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - step_k;
        if (rem_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    // Result register loads once on DONE entry and holds until the next one.
    if (state_d == S_DONE && state_q != S_DONE) begin
      data_out_d = work_d;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      op_q        <= '0;
      rem_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter at WIDTH=16, STEP=4.
`timescale 1ns/1ps
module tb_iter_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;

  int n_vec;
  int n_err;

  iter_shifter #(.WIDTH(16), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE (called at a negedge), check latency and
  // result, optionally stall the consumer, then complete the handshake.
  task automatic do_cmd(input string name, input logic [2:0] o, input logic [15:0] d,
                        input logic [3:0] s, input int exp_lat,
                        input logic [15:0] exp_d, input int hold);
    int lat;
    chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    data_in   = d;
    shamt     = s;
    op        = o;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Scramble inputs after acceptance; they must not matter.
    in_valid = 1'b0;
    data_in  = ~d;
    shamt    = ~s;
    op       = o ^ 3'b011;
    while (!out_valid && lat < 40) begin
      chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_data"}, 32'(data_out), 32'(exp_d));
    chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({name, "_hold_data"}, 32'(data_out), 32'(exp_d));
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({name, "_data_kept"}, 32'(data_out), 32'(exp_d));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in   = 16'h0;
    shamt     = 4'h0;
    op        = 3'b000;
    out_ready = 1'b0;

    #12;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_cmd("srl9",   3'b011, 16'hF0F0, 4'd9,  4, 16'h0078, 0);
    do_cmd("sra15",  3'b100, 16'h8001, 4'd15, 5, 16'hFFFF, 0);
    do_cmd("rol4",   3'b000, 16'h8001, 4'd4,  2, 16'h0018, 0);
    do_cmd("ror8",   3'b010, 16'h1234, 4'd8,  3, 16'h3412, 0);
    do_cmd("sll0",   3'b001, 16'hABCD, 4'd0,  1, 16'hABCD, 0);
    do_cmd("rsvd",   3'b110, 16'h5555, 4'd7,  1, 16'h5555, 0);
    do_cmd("bp_sll", 3'b001, 16'h00F3, 4'd5,  3, 16'h1E60, 3);
    do_cmd("rol15",  3'b000, 16'h0001, 4'd15, 5, 16'h8000, 0);

    // Reset in the middle of a SHIFT sequence.
    in_valid = 1'b1;
    data_in  = 16'hFFFF;
    shamt    = 4'd12;
    op       = 3'b001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    do_cmd("srl15", 3'b011, 16'h8000, 4'd15, 5, 16'h0001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
